// File: rtl/icompare_stats.sv
// rtl/icompare_stats.sv - multi-channel aligned interpolator comparison with windowed error statistics
module icompare_stats #(
    parameter int NCH  = 5,
    parameter int INW  = 28,
    parameter int DLYW = 3,
    parameter int ACCW = 64,
    parameter int WINW = 20
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_ce,
    input  logic [NCH*INW-1:0]     i_data,
    input  logic [NCH*DLYW-1:0]    i_dly,
    input  logic [$clog2(NCH)-1:0] i_ref,
    input  logic [$clog2(NCH)-1:0] i_sel,
    input  logic                   i_start,
    input  logic [WINW-1:0]        i_win,
    output logic                   o_ce,
    output logic [INW-1:0]         o_data,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [NCH*ACCW-1:0]    o_err,
    output logic [NCH*INW-1:0]     o_peak
);
    localparam int SELW  = $clog2(NCH);
    localparam int DEPTH = 1 << DLYW;
    localparam int SQW   = 2*INW + 2;

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_RUN, S_DRAIN, S_DONE} state_t;
    state_t state, state_nx;

    logic [DLYW-1:0] skip_cnt;
    logic [WINW-1:0] win_len;
    logic [WINW-1:0] win_cnt;
    logic            drain_cnt;
    logic            mark;

    // Depth 0 is the live input, so only depths 1..DEPTH-1 need storage.
    logic [INW-1:0]  dline   [NCH][1:DEPTH-1];
    logic [INW-1:0]  aligned [NCH];
    logic [SELW-1:0] ref_idx;

    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            aligned[k] = i_data[k*INW +: INW];
            if (i_dly[k*DLYW +: DLYW] != '0)
                aligned[k] = dline[k][i_dly[k*DLYW +: DLYW]];
        end
    end

    assign ref_idx = (32'(i_ref) < NCH) ? i_ref : '0;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int k = 0; k < NCH; k++)
                for (int j = 1; j < DEPTH; j++)
                    dline[k][j] <= '0;
        end else if (i_ce) begin
            for (int k = 0; k < NCH; k++) begin
                dline[k][1] <= i_data[k*INW +: INW];
                for (int j = 2; j < DEPTH; j++)
                    dline[k][j] <= dline[k][j-1];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_ce   <= 1'b0;
            o_data <= '0;
        end else begin
            o_ce <= i_ce;
            if (i_ce)
                o_data <= (32'(i_sel) < NCH) ? aligned[i_sel] : '0;
        end
    end

    logic signed [INW:0]   diff1 [NCH];
    logic signed [SQW-1:0] dext  [NCH];
    logic [SQW-1:0]        sq2   [NCH];
    logic [INW-1:0]        abs2  [NCH];
    logic [ACCW:0]         sum3  [NCH];
    logic [ACCW-1:0]       acc   [NCH];
    logic [INW-1:0]        peak  [NCH];
    logic                  v1, v2;

    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            dext[k] = SQW'(diff1[k]);
            sum3[k] = {1'b0, acc[k]} + (ACCW+1)'(sq2[k]);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            for (int k = 0; k < NCH; k++) begin
                diff1[k] <= '0;
                sq2[k]   <= '0;
                abs2[k]  <= '0;
                acc[k]   <= '0;
                peak[k]  <= '0;
            end
        end else begin
            v1 <= mark;
            v2 <= v1;
            for (int k = 0; k < NCH; k++) begin
                if (mark)
                    diff1[k] <= {aligned[ref_idx][INW-1], aligned[ref_idx]}
                              - {aligned[k][INW-1], aligned[k]};
                if (v1) begin
                    sq2[k]  <= dext[k] * dext[k];
                    abs2[k] <= diff1[k][INW] ? INW'(-diff1[k]) : INW'(diff1[k]);
                end
                if (state == S_IDLE && i_start) begin
                    acc[k]  <= '0;
                    peak[k] <= '0;
                end else if (v2) begin
                    acc[k] <= sum3[k][ACCW] ? '1 : sum3[k][ACCW-1:0];
                    if (abs2[k] > peak[k])
                        peak[k] <= abs2[k];
                end
            end
        end
    end

    always_comb begin
        state_nx = state;
        mark     = 1'b0;
        case (state)
            S_IDLE:  if (i_start) state_nx = (i_win == '0) ? S_DONE : S_FILL;
            S_FILL:  if (i_ce && skip_cnt == DLYW'(1)) state_nx = S_RUN;
            S_RUN: begin
                if (i_ce) begin
                    mark = 1'b1;
                    if (win_cnt == WINW'(1)) state_nx = S_DRAIN;
                end
            end
            S_DRAIN: if (!drain_cnt) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= S_IDLE;
            skip_cnt  <= '0;
            win_len   <= '0;
            win_cnt   <= '0;
            drain_cnt <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        skip_cnt <= '1;
                        win_len  <= i_win;
                    end
                end
                S_FILL: begin
                    if (i_ce) begin
                        skip_cnt <= skip_cnt - DLYW'(1);
                        if (skip_cnt == DLYW'(1)) win_cnt <= win_len;
                    end
                end
                S_RUN: begin
                    if (i_ce) begin
                        win_cnt   <= win_cnt - WINW'(1);
                        drain_cnt <= 1'b1;
                    end
                end
                S_DRAIN: drain_cnt <= 1'b0;
                default: ;
            endcase
        end
    end

    assign o_busy = (state == S_FILL) || (state == S_RUN) || (state == S_DRAIN);

    // Results are latched one clock after the accumulators settle, together with o_done.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_done <= 1'b0;
            o_err  <= '0;
            o_peak <= '0;
        end else begin
            o_done <= (state == S_DONE);
            if (state == S_DONE) begin
                for (int k = 0; k < NCH; k++) begin
                    o_err[k*ACCW +: ACCW] <= acc[k];
                    o_peak[k*INW +: INW]  <= peak[k];
                end
            end
        end
    end
endmodule

// File: tb/tb_icompare_stats.sv
// tb/tb_icompare_stats.sv - randomized self-checking bench for icompare_stats
`timescale 1ns/1ps
module tb_icompare_stats;
    localparam int NCH  = 5;
    localparam int INW  = 8;
    localparam int DLYW = 3;
    localparam int ACCW = 18;
    localparam int WINW = 8;
    localparam int SELW = $clog2(NCH);
    localparam int FILL = (1 << DLYW) - 1;
    localparam longint ACC_MAX = (longint'(1) << ACCW) - 1;

    logic                  i_clk = 1'b0;
    logic                  i_reset, i_ce, i_start;
    logic [NCH*INW-1:0]    i_data;
    logic [NCH*DLYW-1:0]   i_dly;
    logic [SELW-1:0]       i_ref, i_sel;
    logic [WINW-1:0]       i_win;
    logic                  o_ce, o_busy, o_done;
    logic [INW-1:0]        o_data;
    logic [NCH*ACCW-1:0]   o_err;
    logic [NCH*INW-1:0]    o_peak;

    icompare_stats #(.NCH(NCH), .INW(INW), .DLYW(DLYW), .ACCW(ACCW), .WINW(WINW)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_ce(i_ce), .i_data(i_data), .i_dly(i_dly),
        .i_ref(i_ref), .i_sel(i_sel), .i_start(i_start), .i_win(i_win),
        .o_ce(o_ce), .o_data(o_data), .o_busy(o_busy), .o_done(o_done),
        .o_err(o_err), .o_peak(o_peak)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    logic [NCH*INW-1:0] hist[$];
    int     dly [NCH];
    int     ref_ch, sel_ch, cur_mode, gcnt;
    longint prev_err  [NCH];
    int     prev_peak [NCH];

    function automatic int chan(input logic [NCH*INW-1:0] v, input int k);
        logic signed [INW-1:0] s;
        s = v[k*INW +: INW];
        return int'(s);
    endfunction

    function automatic int aligned_now(input int k);
        int idx;
        idx = hist.size() - 1 - dly[k];
        return (idx < 0) ? 0 : chan(hist[idx], k);
    endfunction

    function automatic logic [NCH*INW-1:0] gen(input int mode, input int n);
        logic [NCH*INW-1:0] v;
        int common, val;
        common = int'($urandom_range(255)) - 128;
        for (int k = 0; k < NCH; k++) begin
            case (mode)
                0: val = int'($urandom_range(40)) - 20;
                1: val = common;
                2: val = (k == 2) ? n - 63 : n - 60;
                3: val = (k == 0) ? 127 : (k == 1) ? -128 : 0;
                5: val = 10*k + 1;
                default: val = int'($urandom_range(255)) - 128;
            endcase
            v[k*INW +: INW] = INW'(val);
        end
        return v;
    endfunction

    task automatic cyc(input bit ce, input bit start = 1'b0, input bit rst = 1'b0);
        logic [INW-1:0] exp_d;
        i_ce    = ce;
        i_start = start;
        i_reset = rst;
        i_data  = gen(cur_mode, gcnt);
        for (int k = 0; k < NCH; k++) i_dly[k*DLYW +: DLYW] = DLYW'(dly[k]);
        i_ref = SELW'(ref_ch);
        i_sel = SELW'(sel_ch);
        @(posedge i_clk);
        #1;
        if (rst) begin
            hist.delete();
        end else if (ce) begin
            hist.push_back(i_data);
            if (hist.size() > 16) void'(hist.pop_front());
            gcnt++;
            exp_d = (sel_ch < NCH) ? INW'(aligned_now(sel_ch)) : '0;
            check("o_data", o_data, exp_d);
        end
        check("o_ce", o_ce, !rst && ce);
        i_start = 1'b0;
        i_reset = 1'b0;
    endtask

    task automatic run_window(input int win, input bit mid_start, input string tag);
        longint sum [NCH];
        int     pk  [NCH];
        int     a   [NCH];
        int     r, d, strobes, iter;
        bit     ce;
        for (int k = 0; k < NCH; k++) begin sum[k] = 0; pk[k] = 0; end
        r     = (ref_ch < NCH) ? ref_ch : 0;
        i_win = WINW'(win);
        cyc(1'($urandom_range(1)), 1'b1);
        if (win == 0) begin
            check({tag, "_done_early"}, o_done, 0);
            cyc(1'b0);
            check({tag, "_done"}, o_done, 1);
            check({tag, "_zero"}, |{o_err, o_peak}, 0);
            cyc(1'b0);
            check({tag, "_done_off"}, o_done, 0);
            for (int k = 0; k < NCH; k++) begin prev_err[k] = 0; prev_peak[k] = 0; end
            return;
        end
        strobes = 0;
        iter    = 0;
        while (strobes < FILL + win) begin
            iter++;
            ce = ($urandom_range(3) != 0) || (iter > 4*(FILL + win));
            cyc(ce, mid_start && strobes == FILL + 1);
            check({tag, "_busy"}, o_busy, 1);
            check({tag, "_no_done"}, o_done, 0);
            if (ce) begin
                strobes++;
                if (strobes > FILL) begin
                    for (int k = 0; k < NCH; k++) a[k] = aligned_now(k);
                    for (int k = 0; k < NCH; k++) begin
                        d = a[r] - a[k];
                        sum[k] += longint'(d) * d;
                        if ((d < 0 ? -d : d) > pk[k]) pk[k] = (d < 0 ? -d : d);
                    end
                end
                if (strobes == FILL + 1) begin
                    check({tag, "_hold_err"}, o_err[ACCW +: ACCW], prev_err[1]);
                    check({tag, "_hold_peak"}, o_peak[INW +: INW], prev_peak[1]);
                end
            end
        end
        cyc(1'($urandom_range(1)));
        check({tag, "_drain_busy"}, o_busy, 1);
        check({tag, "_drain_done"}, o_done, 0);
        cyc(1'($urandom_range(1)));
        check({tag, "_pre_done"}, o_done, 0);
        cyc(1'($urandom_range(1)));
        check({tag, "_done"}, o_done, 1);
        for (int k = 0; k < NCH; k++) begin
            prev_err[k]  = (sum[k] > ACC_MAX) ? ACC_MAX : sum[k];
            prev_peak[k] = pk[k];
            check($sformatf("%s_err%0d", tag, k), o_err[k*ACCW +: ACCW], prev_err[k]);
            check($sformatf("%s_peak%0d", tag, k), o_peak[k*INW +: INW], prev_peak[k]);
        end
        cyc(1'b0);
        check({tag, "_done_off"}, o_done, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < NCH; k++) begin dly[k] = 0; prev_err[k] = 0; prev_peak[k] = 0; end
        ref_ch = 0; sel_ch = 0; cur_mode = 0; gcnt = 0;
        i_win = '0;
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        check("rst_o_data", o_data, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_results", |{o_err, o_peak}, 0);

        cur_mode = 1;
        run_window(100, 1'b0, "ident");
        check("ident_all_zero", |{o_err, o_peak}, 0);

        cur_mode = 2; gcnt = 0; dly[0] = 3;
        run_window(20, 1'b0, "align");
        check("align_err2", o_err[2*ACCW +: ACCW], 0);
        dly[0] = 0;
        run_window(20, 1'b1, "ramp");
        check("ramp_err2", o_err[2*ACCW +: ACCW], 9*20);
        check("ramp_peak2", o_peak[2*INW +: INW], 3);

        cur_mode = 3;
        run_window(4, 1'b0, "ext4");
        check("ext4_peak1", o_peak[INW +: INW], 255);
        check("ext4_err1", o_err[ACCW +: ACCW], 260100);
        run_window(5, 1'b1, "ext5");
        check("ext5_sat1", o_err[ACCW +: ACCW], 262143);

        run_window(0, 1'b0, "win0");

        cur_mode = 0; ref_ch = 7;
        for (int k = 0; k < NCH; k++) dly[k] = $urandom_range(7);
        run_window(6, 1'b0, "ref7");
        ref_ch = 0;

        cur_mode = 5;
        for (int k = 0; k < NCH; k++) dly[k] = 0;
        cyc(1'b1);
        for (int s = 0; s <= 6; s++) begin
            if (s == 5) continue;
            sel_ch = s;
            cyc(1'b1);
            check($sformatf("fwd_sel%0d", s), o_data, (s < NCH) ? 10*s + 1 : 0);
        end

        for (int t = 0; t < 8; t++) begin
            for (int k = 0; k < NCH; k++) dly[k] = $urandom_range(7);
            ref_ch   = $urandom_range(7);
            sel_ch   = $urandom_range(7);
            cur_mode = ($urandom_range(1) != 0) ? 0 : 4;
            run_window(int'($urandom_range(12, 1)), 1'($urandom_range(1)), $sformatf("rnd%0d", t));
        end

        cur_mode = 4; i_win = WINW'(10);
        cyc(1'b1, 1'b1);
        for (int i = 0; i < 10; i++) cyc(1'b1);
        cyc(1'b1, 1'b1, 1'b1);
        check("midrst_o_data", o_data, 0);
        check("midrst_busy", o_busy, 0);
        check("midrst_done", o_done, 0);
        check("midrst_results", |{o_err, o_peak}, 0);
        for (int k = 0; k < NCH; k++) begin prev_err[k] = 0; prev_peak[k] = 0; end
        for (int i = 0; i < 25; i++) begin
            cyc(1'b1);
            check("midrst_no_done", o_done, 0);
            check("midrst_idle", o_busy, 0);
        end
        run_window(3, 1'b0, "after_rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
